// File: rtl/inv_mix_columns_iter_pkg.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter_pkg
// Shared definitions for the iterative AES InvMixColumns engine:
//   - COL_W        : width of one AES state column (four bytes)
//   - fsm_state_t  : engine control states IDLE / BUSY / DONE
//   - galois_mult_*: GF(2^8) constant multipliers, reduction polynomial 0x11B,
//                    all built from xtime (galois_mult_2) chains
// ---------------------------------------------------------------------------
package inv_mix_columns_iter_pkg;

    localparam int COL_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // xtime: multiply by x, folding the overflow bit back with 0x1B
    function automatic logic [7:0] galois_mult_2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // 9 = 8 + 1
    function automatic logic [7:0] galois_mult_9(input logic [7:0] x);
        return galois_mult_2(galois_mult_2(galois_mult_2(x))) ^ x;
    endfunction

    // 11 = ((4 + 1) * 2) + 1
    function automatic logic [7:0] galois_mult_11(input logic [7:0] x);
        return galois_mult_2(galois_mult_2(galois_mult_2(x)) ^ x) ^ x;
    endfunction

    // 13 = ((2 + 1) * 4) + 1
    function automatic logic [7:0] galois_mult_13(input logic [7:0] x);
        return galois_mult_2(galois_mult_2(galois_mult_2(x) ^ x)) ^ x;
    endfunction

    // 14 = ((2 + 1) * 2 + 1) * 2
    function automatic logic [7:0] galois_mult_14(input logic [7:0] x);
        return galois_mult_2(galois_mult_2(galois_mult_2(x) ^ x) ^ x);
    endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// ---------------------------------------------------------------------------
// inv_mix_column_word
// Purely combinational InvMixColumns on a single 32-bit column.
// Ports:
//   col_in  [31:0] : input column, byte 0 (a0) in bits [31:24]
//   col_out [31:0] : transformed column, same byte order
// ---------------------------------------------------------------------------
module inv_mix_column_word
    import inv_mix_columns_iter_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Each output row is a rotation of the {0e, 0b, 0d, 09} coefficient row
    assign r0 = galois_mult_14(a0) ^ galois_mult_11(a1) ^ galois_mult_13(a2) ^ galois_mult_9(a3);
    assign r1 = galois_mult_9(a0)  ^ galois_mult_14(a1) ^ galois_mult_11(a2) ^ galois_mult_13(a3);
    assign r2 = galois_mult_13(a0) ^ galois_mult_9(a1)  ^ galois_mult_14(a2) ^ galois_mult_11(a3);
    assign r3 = galois_mult_11(a0) ^ galois_mult_13(a1) ^ galois_mult_9(a2)  ^ galois_mult_14(a3);

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// inv_mix_columns_iter
// Iterative AES InvMixColumns engine for the decrypt round loop. A 128-bit
// state is captured, then transformed COLS_PER_CYCLE columns per clock, and
// the result is held until the downstream side takes it.
// Parameters:
//   COLS_PER_CYCLE : 1, 2 or 4 columns per BUSY cycle
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : data_in carries a state to transform
//   in_ready  : engine is idle and will accept a state
//   data_in   : AES state, column c in bits [127-32c -: 32]
//   out_valid : data_out carries a completed result
//   out_ready : downstream takes data_out this cycle
//   data_out  : InvMixColumns(data_in), same layout, always registered
// ---------------------------------------------------------------------------
module inv_mix_columns_iter
    import inv_mix_columns_iter_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int         NUM_COLS   = 4;
    localparam logic [1:0] COL_STEP   = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_GROUP = 2'(NUM_COLS - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    fsm_state_t   state;
    logic [127:0] src;
    logic [127:0] res;
    logic [1:0]   col_cnt;

    logic [COL_W-1:0] grp_in   [COLS_PER_CYCLE];
    logic [COL_W-1:0] grp_out  [COLS_PER_CYCLE];
    logic [6:0]       col_base [COLS_PER_CYCLE];

    // One column transformer per lane. Lane g handles column col_cnt+g; the
    // low bit offset of column c is (3-c)*32, and 3-c is just ~c in two bits.
    // col_cnt is always a multiple of COLS_PER_CYCLE, so lanes never wrap.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        logic [1:0] col_idx;
        assign col_idx     = col_cnt + 2'(g);
        assign col_base[g] = {~col_idx, 5'b0};
        assign grp_in[g]   = src[col_base[g] +: COL_W];

        inv_mix_column_word u_word (
            .col_in  (grp_in[g]),
            .col_out (grp_out[g])
        );
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign data_out  = res;

    // Control FSM plus datapath registers. src is only written on accept, so
    // input changes during BUSY/DONE cannot disturb the result; res only
    // changes in BUSY, so data_out stays stable while stalled in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src     <= '0;
            res     <= '0;
            col_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src     <= data_in;
                        col_cnt <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        res[col_base[g] +: COL_W] <= grp_out[g];
                    end
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_cnt == LAST_GROUP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
